// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU control codes and exec-unit state encoding shared with
//               the ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Operation-in / result-out handshake bundle of the exec unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_ctrl, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb_core
// Description : Single-cycle logic/arithmetic ops and unsupported-code flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [3:0]       ctrl_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic      [WIDTH-1:0] result_o,
    output logic                  illegal_o
);

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        unique case (ctrl_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_NOR: result_o = ~(a_i | b_i);
            // Shifts are sequenced by the parent; they are legal but produce nothing here.
            ALU_SLL, ALU_SRL: result_o = '0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Handshaked ALU execute stage; single-cycle ops plus
//               1-bit-per-cycle iterative shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_exec_unit_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic             dir_right_q;
    logic [SHW-1:0]   cnt_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] core_result;
    logic             core_illegal;
    logic [WIDTH-1:0] shifted;

    assign accept  = bus.in_valid && in_ready;
    assign shamt   = bus.operand_b[SHW-1:0];
    assign shifted = dir_right_q ? (result_q >> 1) : (result_q << 1);

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .ctrl_i    (bus.alu_ctrl),
        .a_i       (bus.operand_a),
        .b_i       (bus.operand_b),
        .result_o  (core_result),
        .illegal_o (core_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift(bus.alu_ctrl) && (shamt != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // result_q doubles as the shift register so the final shift step lands directly in the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            dir_right_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift(bus.alu_ctrl)) begin
                            result_q    <= bus.operand_a;
                            zero_q      <= (bus.operand_a == '0);
                            illegal_q   <= 1'b0;
                            dir_right_q <= (bus.alu_ctrl == ALU_SRL);
                            cnt_q       <= shamt;
                        end else begin
                            result_q  <= core_result;
                            zero_q    <= (core_result == '0);
                            illegal_q <= core_illegal;
                            cnt_q     <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= shifted;
                    zero_q   <= (shifted == '0);
                    cnt_q    <= cnt_q - SHW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU control code that the ALU control decoder produces.
- Registers one operation at a time under a valid/ready handshake and executes it: single-cycle logic/arithmetic, or iterative 1-bit-per-cycle shifts.
- Presents result, zero flag and illegal flag under a second valid/ready handshake to the writeback/branch stage of the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  unit can accept an operation.
- alu_ctrl  input  4  ALU control code.
- operand_a  input  WIDTH  first operand.
- operand_b  input  WIDTH  second operand; the shift amount is operand_b[SHW-1:0].
- out_valid  output  1  result is available.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  high when result == 0.
- illegal  output  1  high when alu_ctrl was an unsupported code.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Control codes:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH); 0110 SUB (a-b, wraps).
  - 0111 SLT: signed compare, result 1 or 0.
  - 1100 NOR.
  - 1000 SLL: iterative. 1001 SRL: iterative, logical.
  - Any other code: result 0, illegal=1, zero=1.
- States: IDLE, SHIFT, DONE. Encoding constants come from the package.
- in_ready = (state==IDLE). Combinational from state only.
- Accept occurs when in_valid && in_ready. Operands and code are captured at accept. Inputs outside accept are ignored.
- IDLE, accept of a non-shift code: compute, register result/zero/illegal, go to DONE. out_valid is high the cycle after accept (latency 1).
- IDLE, accept of SLL/SRL:
  - Load a shift register with operand_a and a down-counter with shamt.
  - shamt==0: go straight to DONE with result=operand_a (latency 1).
  - Otherwise go to SHIFT.
- SHIFT: each cycle shift by 1 and decrement the counter. When the counter reaches 0, go to DONE. Total latency shamt+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1; result, zero and illegal are held stable.
  - out_ready=1 completes the handshake and returns to IDLE next cycle. No same-cycle re-accept, so back-to-back throughput is one operation per 2 cycles minimum.
  - out_ready=0: hold indefinitely (backpressure).
- out_valid is low in IDLE and SHIFT. result, zero and illegal are don't-care while out_valid=0, but must not be X after reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0, counter=0.
- Reset asserted mid-SHIFT or in DONE: the operation is discarded and all state clears asynchronously. The first posedge after deassertion starts in IDLE.
- out_ready while out_valid=0: ignored.
- in_valid held high across DONE: the new op is accepted only in the IDLE cycle that follows.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRL).
  - State enum typedef.
  - This is the same constant set the control decoder will import.
- One natural sub-module, alu_comb_core: purely combinational single-cycle ops plus the illegal flag, instantiated once. The FSM, shifter and counter stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT (SLL with shamt=20, reset at cycle 5) -> out_valid=0 and in_ready=1 immediately; next op behaves normally.
- ADD/SUB/zero: ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, zero=0, latency 1. SUB a=5, b=5 -> result 0, zero=1. SUB a=0, b=1 -> 0xFFFFFFFF.
- Logic/SLT: AND 0xF0F0,0x0FF0 -> 0x00F0. OR -> 0xFFF0. NOR 0,0 -> 0xFFFFFFFF. SLT a=0xFFFFFFFF, b=1 -> 1. SLT a=1, b=0xFFFFFFFF -> 0.
- Shifts: SLL a=1, b=31 -> 0x80000000 with out_valid 32 cycles after accept. SRL a=0x80000000, b=0x24 (shamt 4) -> 0x08000000, latency 5. SLL shamt=0 -> a, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid and result stable, in_ready=0; release -> in_ready=1 next cycle.
- Illegal: alu_ctrl=0101 -> illegal=1, result=0, zero=1. The next legal ADD clears illegal.
